// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

  // Iteration counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Load/enable control and result bundle between a datapath controller and the divider.
interface seq_divider_if #(parameter int WIDTH = divider_pkg::DIV_WIDTH_DEFAULT);

  logic                 load;
  logic                 enable;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic                 overflow;
  logic                 zero_flag;

  modport master (
    output load, enable, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow, zero_flag
  );

  modport slave (
    input  load, enable, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow, zero_flag
  );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Purely combinational, no backpressure.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] r,
  input  logic             qmsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0] tmp;

  // r < d on entry, so tmp < 2d and the difference always fits in WIDTH bits.
  always_comb begin
    tmp    = {r, qmsb};
    qbit   = (tmp >= {1'b0, d});
    r_next = qbit ? (tmp[WIDTH-1:0] - d) : tmp[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, 2W/W -> W quotient + W remainder.
// Latency W+2 cycles from load (2 on divide-by-zero/overflow); enable low stalls RUN.
// Load is ignored while busy; results are held in DONE until the next accepted load.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             dbz_q, ovf_q, zf_q;
  logic             busy_c, done_c;

  logic [WIDTH-1:0] r_next, q_shift;
  logic             qbit;
  logic             load_ok, last_step, d_zero, too_big;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .qmsb   (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (r_next),
    .qbit   (qbit)
  );

  assign load_ok   = bus.load && (state == IDLE || state == DONE);
  assign last_step = bus.enable && (cnt_q == CW'(1));
  assign d_zero    = (d_q == '0);
  assign too_big   = (r_q >= d_q);
  assign q_shift   = {q_q[WIDTH-2:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_ok) state_nxt = CHECK;
      CHECK:   state_nxt = (d_zero || too_big) ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (load_ok) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CHECK, RUN: busy_c = 1'b1;
      DONE:       done_c = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_ok) begin
            d_q   <= bus.divisor;
            r_q   <= bus.dividend[2*WIDTH-1:WIDTH];
            q_q   <= bus.dividend[WIDTH-1:0];
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            zf_q  <= 1'b0;
          end
        end
        CHECK: begin
          // A high half >= divisor means the quotient needs more than WIDTH bits.
          if (d_zero || too_big) begin
            dbz_q <= d_zero;
            ovf_q <= !d_zero;
            zf_q  <= 1'b0;
            quo_q <= '1;
            rem_q <= '0;
          end else begin
            cnt_q <= CW'(WIDTH);
          end
        end
        RUN: begin
          if (bus.enable) begin
            r_q   <= r_next;
            q_q   <= q_shift;
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
              quo_q <= q_shift;
              rem_q <= r_next;
              zf_q  <= (q_shift == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.zero_flag   = zf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, stalls, ignored loads,
// mid-run reset and randomized operands against an arithmetic reference model.
module tb_seq_divider;

  typedef struct packed {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    logic        zf;
    logic [7:0]  lat;
  } vec_t;

  localparam vec_t TBL [6] = '{
    '{16'h0009, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 8'd10},
    '{16'h7FFF, 8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 8'd10},
    '{16'h0002, 8'h05, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 8'd10},
    '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2},
    '{16'h0300, 8'h03, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2},
    '{16'h02FF, 8'h03, 8'hFF, 8'h02, 1'b0, 1'b0, 1'b0, 8'd10}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected result from plain integer division; latency is W+2 plus stalled cycles.
  function automatic vec_t model(input logic [15:0] dd, input logic [7:0] dv, input int sl);
    vec_t        m;
    int unsigned qq;
    m     = '0;
    m.dd  = dd;
    m.dv  = dv;
    if (dv == 8'h00) begin
      m.dbz = 1'b1; m.q = 8'hFF; m.r = 8'h00; m.lat = 8'd2;
    end else begin
      qq = dd / dv;
      if (qq > 255) begin
        m.ovf = 1'b1; m.q = 8'hFF; m.r = 8'h00; m.lat = 8'd2;
      end else begin
        m.q   = qq[7:0];
        m.r   = 8'(dd % dv);
        m.zf  = (qq == 0);
        m.lat = 8'(10 + sl);
      end
    end
    return m;
  endfunction

  // Drive one operation; lat = rising edges after the load is driven until done is seen.
  task automatic do_op(input logic [15:0] dd, input logic [7:0] dv, input int sa,
                       input int sl, input bit ghost, output int lat);
    @(posedge clk); #1;
    bus.load     = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.enable   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      bus.load   = 1'b0;
      bus.enable = !(sl > 0 && lat >= sa && lat < sa + sl);
      if (ghost && lat == 4) begin
        bus.load     = 1'b1;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
      end
    end while (!bus.done && lat < 60);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.enable = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.quotient, bus.remainder} !== 16'h0000) begin
      errors++; $display("FAIL reset_results: got %h want 0000", {bus.quotient, bus.remainder});
    end
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.zero_flag} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.zero_flag});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(TBL[i].dd, TBL[i].dv, 0, 0, 1'b0, lat);
      checks++; if (lat !== int'(TBL[i].lat)) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, TBL[i].lat); end
      checks++; if (bus.quotient !== TBL[i].q) begin errors++; $display("FAIL dir_quotient[%0d]: got %h want %h", i, bus.quotient, TBL[i].q); end
      checks++; if (bus.remainder !== TBL[i].r) begin errors++; $display("FAIL dir_remainder[%0d]: got %h want %h", i, bus.remainder, TBL[i].r); end
      checks++;
      if ({bus.div_by_zero, bus.overflow, bus.zero_flag} !== {TBL[i].dbz, TBL[i].ovf, TBL[i].zf}) begin
        errors++; $display("FAIL dir_flags[%0d]: got %b want %b", i,
                           {bus.div_by_zero, bus.overflow, bus.zero_flag}, {TBL[i].dbz, TBL[i].ovf, TBL[i].zf});
      end
    end
  endtask

  task automatic test_stall_ignored_load();
    int lat;
    do_op(16'h00C8, 8'h07, 4, 3, 1'b1, lat);
    checks++; if (lat !== 13) begin errors++; $display("FAIL stall_latency: got %0d want 13", lat); end
    checks++; if (bus.quotient !== 8'h1C) begin errors++; $display("FAIL stall_quotient: got %h want 1c", bus.quotient); end
    checks++; if (bus.remainder !== 8'h04) begin errors++; $display("FAIL stall_remainder: got %h want 04", bus.remainder); end
    // Results must be held while sitting in DONE with load low.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 8'h1C, 8'h04}) begin
      errors++; $display("FAIL stall_hold: got %h want 11c04", {bus.done, bus.quotient, bus.remainder});
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    do_op(16'h1234, 8'h56, 0, 0, 1'b0, lat);
    checks++; if (bus.quotient !== 8'd54) begin errors++; $display("FAIL pre_quotient: got %h want 36", bus.quotient); end
    @(posedge clk); #1;
    bus.load = 1'b1; bus.dividend = 16'h0009; bus.divisor = 8'h03; bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b want 1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.zero_flag} !== 21'h0) begin
      errors++; $display("FAIL midrun_reset: got %h want 0",
                         {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.zero_flag});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", {bus.busy, bus.done}); end
    do_op(16'h1234, 8'h56, 0, 0, 1'b0, lat);
    do_op(16'h0009, 8'h03, 0, 0, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL restart_latency: got %0d want 10", lat); end
    checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL restart_quotient: got %h want 03", bus.quotient); end
    checks++; if (bus.remainder !== 8'h00) begin errors++; $display("FAIL restart_remainder: got %h want 00", bus.remainder); end
  endtask

  task automatic test_random();
    int          lat, sa, sl;
    bit          ghost;
    logic [15:0] dd;
    logic [7:0]  dv;
    vec_t        e;
    for (int i = 0; i < 30; i++) begin
      dv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      dd = 16'($urandom);
      if (dv != 8'h00 && $urandom_range(0, 2) != 0) dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
      sl    = $urandom_range(0, 3);
      sa    = $urandom_range(2, 7);
      ghost = 1'($urandom_range(0, 1));
      e     = model(dd, dv, sl);
      do_op(dd, dv, sa, sl, ghost, lat);
      checks++; if (lat !== int'(e.lat)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d (%h/%h)", i, lat, e.lat, dd, dv); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL rnd_quotient[%0d]: got %h want %h (%h/%h)", i, bus.quotient, e.q, dd, dv); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL rnd_remainder[%0d]: got %h want %h (%h/%h)", i, bus.remainder, e.r, dd, dv); end
      checks++;
      if ({bus.div_by_zero, bus.overflow, bus.zero_flag} !== {e.dbz, e.ovf, e.zf}) begin
        errors++; $display("FAIL rnd_flags[%0d]: got %b want %b (%h/%h)", i,
                           {bus.div_by_zero, bus.overflow, bus.zero_flag}, {e.dbz, e.ovf, e.zf}, dd, dv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_ignored_load();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
